// File: rtl/cu_sm_mw_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit with memory wait states:
// opcodes, state encodings, datapath mux encodings and the control word layout.
package cu_sm_mw_pkg;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;

    typedef enum logic [3:0] {
        ST_RST      = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEMADR   = 4'd3,
        ST_MEMRD    = 4'd4,
        ST_MEMWB    = 4'd5,
        ST_MEMWR    = 4'd6,
        ST_EXEC     = 4'd7,
        ST_RTYPE_WB = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_ADDI_EX  = 4'd11,
        ST_ADDI_WB  = 4'd12,
        ST_JAL      = 4'd13,
        ST_EXC      = 4'd14
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_ILLEGAL = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT = 2'b10;

    typedef struct packed {
        logic [1:0] reg_dst;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_op;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ir_write;
        logic       i_or_d;
        logic       instr_done;
    } ctrl_t;

    // Successor of DECODE for a 6-bit opcode; unknown opcodes trap.
    function automatic state_t decode_dispatch(input logic [5:0] op);
        state_t nxt;
        case (op)
            OP_R:           nxt = ST_EXEC;
            OP_LW, OP_SW:   nxt = ST_MEMADR;
            OP_BEQ, OP_BNE: nxt = ST_BRANCH;
            OP_ADDI:        nxt = ST_ADDI_EX;
            OP_J:           nxt = ST_JUMP;
            OP_JAL:         nxt = ST_JAL;
            default:        nxt = ST_EXC;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/cu_sm_mw_mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory-wait state and flags a timeout
// on the MAX_WAIT-th such cycle; MAX_WAIT=0 disables the timeout.
module mem_wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);

    localparam int unsigned CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [CW-1:0] LAST = CW'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);
    localparam bit ENABLED = (MAX_WAIT != 0);

    logic [CW-1:0] wait_cnt;

    // The FSM leaves a wait state exactly when mem_ready or timeout is seen,
    // so clearing on those conditions clears on every state change.
    assign timeout = ENABLED && active && !mem_ready && (wait_cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (active && !mem_ready && !timeout) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

endmodule

// File: rtl/cu_sm_mw.sv
// Multi-cycle MIPS control FSM with memory wait-state handshake, timeout and
// illegal-opcode exception, per-instruction completion pulse and debug state.
module cu_sm_mw
    import cu_sm_mw_pkg::*;
#(
    parameter int unsigned OPW      = 7,
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned SW       = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] op_code,
    input  logic           mem_ready,
    input  logic           exc_clear,
    output logic [1:0]     RegDst,
    output logic           RegWrite,
    output logic           Memwrite,
    output logic           Memread,
    output logic [1:0]     Memtoreg,
    output logic [1:0]     ALUop,
    output logic           PCwrite_cond,
    output logic           branch_ne,
    output logic           PCwrite,
    output logic [1:0]     PCsrc,
    output logic           ALUsrcA,
    output logic [1:0]     ALUsrcB,
    output logic           IRwrite,
    output logic           IorD,
    output logic           instr_done,
    output logic           exc,
    output logic [1:0]     exc_code,
    output logic [SW-1:0]  state
);

    state_t     cur_state, next_state;
    logic [1:0] exc_code_q, exc_code_d;
    logic       wait_active;
    logic       timeout;
    logic       op_upper_zero;
    logic [5:0] op_low;
    ctrl_t      ctl;

    assign op_low        = op_code[5:0];
    assign op_upper_zero = ((op_code >> 6) == '0);
    assign wait_active   = (cur_state == ST_FETCH) || (cur_state == ST_MEMRD) ||
                           (cur_state == ST_MEMWR);

    mem_wait_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .active   (wait_active),
        .mem_ready(mem_ready),
        .timeout  (timeout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state  <= ST_RST;
            exc_code_q <= EXC_NONE;
        end else begin
            cur_state  <= next_state;
            exc_code_q <= exc_code_d;
        end
    end

    always_comb begin
        next_state = cur_state;
        exc_code_d = exc_code_q;
        ctl        = '0;
        case (cur_state)
            ST_RST: begin
                next_state = ST_FETCH;
            end
            ST_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = SRCB_FOUR;
                ctl.alu_op    = ALU_ADD;
                ctl.pc_src    = PCSRC_ALU;
                ctl.ir_write  = mem_ready;
                ctl.pc_write  = mem_ready;
                if (mem_ready) begin
                    next_state = ST_DECODE;
                end else if (timeout) begin
                    next_state = ST_EXC;
                    exc_code_d = EXC_TIMEOUT;
                end
            end
            ST_DECODE: begin
                ctl.alu_src_b = SRCB_IMM_SH;
                ctl.alu_op    = ALU_ADD;
                next_state    = op_upper_zero ? decode_dispatch(op_low) : ST_EXC;
                if (next_state == ST_EXC) begin
                    exc_code_d = EXC_ILLEGAL;
                end
            end
            ST_MEMADR, ST_ADDI_EX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALU_ADD;
                if (cur_state == ST_ADDI_EX) begin
                    next_state = ST_ADDI_WB;
                end else begin
                    next_state = (op_low == OP_LW) ? ST_MEMRD : ST_MEMWR;
                end
            end
            ST_MEMRD: begin
                ctl.mem_read = 1'b1;
                ctl.i_or_d   = 1'b1;
                if (mem_ready) begin
                    next_state = ST_MEMWB;
                end else if (timeout) begin
                    next_state = ST_EXC;
                    exc_code_d = EXC_TIMEOUT;
                end
            end
            ST_MEMWB: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = RD_RT;
                ctl.mem_to_reg = M2R_MDR;
                ctl.instr_done = 1'b1;
                next_state     = ST_FETCH;
            end
            ST_MEMWR: begin
                ctl.mem_write  = 1'b1;
                ctl.i_or_d     = 1'b1;
                ctl.instr_done = mem_ready;
                if (mem_ready) begin
                    next_state = ST_FETCH;
                end else if (timeout) begin
                    next_state = ST_EXC;
                    exc_code_d = EXC_TIMEOUT;
                end
            end
            ST_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_B;
                ctl.alu_op    = ALU_FUNCT;
                next_state    = ST_RTYPE_WB;
            end
            ST_RTYPE_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = RD_RD;
                ctl.mem_to_reg = M2R_ALUOUT;
                ctl.instr_done = 1'b1;
                next_state     = ST_FETCH;
            end
            ST_ADDI_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = RD_RT;
                ctl.mem_to_reg = M2R_ALUOUT;
                ctl.instr_done = 1'b1;
                next_state     = ST_FETCH;
            end
            ST_BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_src_b     = SRCB_B;
                ctl.alu_op        = ALU_SUB;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_src        = PCSRC_ALUOUT;
                ctl.branch_ne     = (op_code == OPW'(OP_BNE));
                ctl.instr_done    = 1'b1;
                next_state        = ST_FETCH;
            end
            ST_JUMP: begin
                ctl.pc_write   = 1'b1;
                ctl.pc_src     = PCSRC_JUMP;
                ctl.instr_done = 1'b1;
                next_state     = ST_FETCH;
            end
            ST_JAL: begin
                ctl.pc_write   = 1'b1;
                ctl.pc_src     = PCSRC_JUMP;
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = RD_RA;
                ctl.mem_to_reg = M2R_PC;
                ctl.instr_done = 1'b1;
                next_state     = ST_FETCH;
            end
            ST_EXC: begin
                if (exc_clear) begin
                    next_state = ST_FETCH;
                    exc_code_d = EXC_NONE;
                end
            end
            default: begin
                next_state = ST_FETCH;
            end
        endcase
    end

    assign RegDst       = ctl.reg_dst;
    assign RegWrite     = ctl.reg_write;
    assign Memwrite     = ctl.mem_write;
    assign Memread      = ctl.mem_read;
    assign Memtoreg     = ctl.mem_to_reg;
    assign ALUop        = ctl.alu_op;
    assign PCwrite_cond = ctl.pc_write_cond;
    assign branch_ne    = ctl.branch_ne;
    assign PCwrite      = ctl.pc_write;
    assign PCsrc        = ctl.pc_src;
    assign ALUsrcA      = ctl.alu_src_a;
    assign ALUsrcB      = ctl.alu_src_b;
    assign IRwrite      = ctl.ir_write;
    assign IorD         = ctl.i_or_d;
    assign instr_done   = ctl.instr_done;
    assign exc          = (cur_state == ST_EXC);
    assign exc_code     = exc_code_q;
    assign state        = SW'(cur_state);

endmodule

// File: tb/tb_cu_sm_mw.sv
// Bench for cu_sm_mw: directed vector table, hand-written wait/timeout/reset
// sequences, and random instruction streams planned from the instruction rules.
module tb_cu_sm_mw;

    localparam int unsigned OPW  = 7;
    localparam int          MAXW = 15;

    localparam int S_RST = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMRD = 4;
    localparam int S_MEMWB = 5, S_MEMWR = 6, S_EXEC = 7, S_RTYPE_WB = 8, S_BRANCH = 9;
    localparam int S_JUMP = 10, S_ADDI_EX = 11, S_ADDI_WB = 12, S_JAL = 13, S_EXC = 14;

    typedef struct packed {
        logic [1:0] regdst;
        logic       regwrite, memwrite, memread;
        logic [1:0] memtoreg, aluop;
        logic       pcwc, bne, pcwrite;
        logic [1:0] pcsrc;
        logic       srca;
        logic [1:0] srcb;
        logic       irwrite, iord, done, exc;
        logic [1:0] code;
    } ctl_t;

    typedef struct {
        logic [6:0] op;
        bit         rdy;
        bit         clr;
        int         st;
        logic [1:0] code;
    } vec_t;

    logic clk = 1'b0, rst = 1'b0, rst0 = 1'b0, mem_ready = 1'b0, exc_clear = 1'b0;
    logic [OPW-1:0] op_code = '0;

    logic [1:0] RegDst, Memtoreg, ALUop, PCsrc, ALUsrcB, exc_code;
    logic RegWrite, Memwrite, Memread, PCwrite_cond, branch_ne, PCwrite, ALUsrcA;
    logic IRwrite, IorD, instr_done, exc;
    logic [3:0] state;

    logic [1:0] d0_RegDst, d0_Memtoreg, d0_ALUop, d0_PCsrc, d0_ALUsrcB, d0_exc_code;
    logic d0_RegWrite, d0_Memwrite, d0_Memread, d0_PCwrite_cond, d0_branch_ne, d0_PCwrite;
    logic d0_ALUsrcA, d0_IRwrite, d0_IorD, d0_instr_done, d0_exc;
    logic [3:0] d0_state;

    ctl_t got, got0;
    assign got  = {RegDst, RegWrite, Memwrite, Memread, Memtoreg, ALUop, PCwrite_cond,
                   branch_ne, PCwrite, PCsrc, ALUsrcA, ALUsrcB, IRwrite, IorD,
                   instr_done, exc, exc_code};
    assign got0 = {d0_RegDst, d0_RegWrite, d0_Memwrite, d0_Memread, d0_Memtoreg, d0_ALUop,
                   d0_PCwrite_cond, d0_branch_ne, d0_PCwrite, d0_PCsrc, d0_ALUsrcA,
                   d0_ALUsrcB, d0_IRwrite, d0_IorD, d0_instr_done, d0_exc, d0_exc_code};

    cu_sm_mw #(.OPW(OPW), .MAX_WAIT(MAXW), .SW(4)) dut (
        .clk(clk), .rst(rst), .op_code(op_code), .mem_ready(mem_ready),
        .exc_clear(exc_clear), .RegDst(RegDst), .RegWrite(RegWrite),
        .Memwrite(Memwrite), .Memread(Memread), .Memtoreg(Memtoreg), .ALUop(ALUop),
        .PCwrite_cond(PCwrite_cond), .branch_ne(branch_ne), .PCwrite(PCwrite),
        .PCsrc(PCsrc), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .IRwrite(IRwrite),
        .IorD(IorD), .instr_done(instr_done), .exc(exc), .exc_code(exc_code),
        .state(state)
    );

    cu_sm_mw #(.OPW(OPW), .MAX_WAIT(0), .SW(4)) dut0 (
        .clk(clk), .rst(rst0), .op_code(op_code), .mem_ready(mem_ready),
        .exc_clear(exc_clear), .RegDst(d0_RegDst), .RegWrite(d0_RegWrite),
        .Memwrite(d0_Memwrite), .Memread(d0_Memread), .Memtoreg(d0_Memtoreg),
        .ALUop(d0_ALUop), .PCwrite_cond(d0_PCwrite_cond), .branch_ne(d0_branch_ne),
        .PCwrite(d0_PCwrite), .PCsrc(d0_PCsrc), .ALUsrcA(d0_ALUsrcA),
        .ALUsrcB(d0_ALUsrcB), .IRwrite(d0_IRwrite), .IorD(d0_IorD),
        .instr_done(d0_instr_done), .exc(d0_exc), .exc_code(d0_exc_code),
        .state(d0_state)
    );

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_bad = 0;
    string tag   = "reset";

    // Output table per state, straight from the per-state output rules.
    function automatic ctl_t exp_ctl(input int st, input bit rdy, input logic [6:0] op,
                                     input logic [1:0] code);
        ctl_t c = '0;
        c.code = code;
        case (st)
            S_FETCH:    begin c.memread = 1; c.srcb = 2'b01; c.irwrite = rdy; c.pcwrite = rdy; end
            S_DECODE:   c.srcb = 2'b11;
            S_MEMADR, S_ADDI_EX: begin c.srca = 1; c.srcb = 2'b10; end
            S_MEMRD:    begin c.memread = 1; c.iord = 1; end
            S_MEMWB:    begin c.regwrite = 1; c.memtoreg = 2'b01; c.done = 1; end
            S_MEMWR:    begin c.memwrite = 1; c.iord = 1; c.done = rdy; end
            S_EXEC:     begin c.srca = 1; c.aluop = 2'b10; end
            S_RTYPE_WB: begin c.regwrite = 1; c.regdst = 2'b01; c.done = 1; end
            S_ADDI_WB:  begin c.regwrite = 1; c.done = 1; end
            S_BRANCH:   begin c.srca = 1; c.aluop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01;
                              c.bne = (op == 7'h05); c.done = 1; end
            S_JUMP:     begin c.pcwrite = 1; c.pcsrc = 2'b10; c.done = 1; end
            S_JAL:      begin c.pcwrite = 1; c.pcsrc = 2'b10; c.regwrite = 1;
                              c.regdst = 2'b10; c.memtoreg = 2'b10; c.done = 1; end
            S_EXC:      c.exc = 1;
            default:    c = '0;
        endcase
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] g, input logic [31:0] e);
        n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, g, e, $time);
        end
    endtask

    task automatic apply(input logic [6:0] op, input bit rdy, input bit clr, input int st,
                         input logic [1:0] code);
        @(negedge clk);
        op_code   = op;
        mem_ready = rdy;
        exc_clear = clr;
        #1;
        check({tag, " state"}, 32'(state), 32'(st));
        check({tag, " ctl"}, 32'(got), 32'(exp_ctl(st, rdy, op, code)));
    endtask

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    task automatic step(input logic [6:0] op, input int st);
        apply(op, rb(), rb(), st, 2'b00);
    endtask

    task automatic take_exc(input logic [6:0] op, input logic [1:0] code);
        int k = int'($urandom_range(0, 2));
        for (int i = 0; i < k; i++) apply(op, rb(), 1'b0, S_EXC, code);
        apply(op, rb(), 1'b1, S_EXC, code);
    endtask

    // w not-ready cycles then ready; MAXW or more not-ready cycles trap instead.
    task automatic mem_phase(input logic [6:0] op, input int st, input int w, output bit to);
        if (w >= MAXW) begin
            for (int i = 0; i < MAXW; i++) apply(op, 1'b0, rb(), st, 2'b00);
            take_exc(op, 2'b10);
            to = 1'b1;
        end else begin
            for (int i = 0; i < w; i++) apply(op, 1'b0, rb(), st, 2'b00);
            apply(op, 1'b1, rb(), st, 2'b00);
            to = 1'b0;
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input int w1, input int w2);
        bit to;
        mem_phase(op, S_FETCH, w1, to);
        if (to) return;
        step(op, S_DECODE);
        case (op)
            7'h00: begin step(op, S_EXEC); step(op, S_RTYPE_WB); end
            7'h23: begin step(op, S_MEMADR); mem_phase(op, S_MEMRD, w2, to);
                         if (!to) step(op, S_MEMWB); end
            7'h2B: begin step(op, S_MEMADR); mem_phase(op, S_MEMWR, w2, to); end
            7'h04, 7'h05: step(op, S_BRANCH);
            7'h08: begin step(op, S_ADDI_EX); step(op, S_ADDI_WB); end
            7'h02: step(op, S_JUMP);
            7'h03: step(op, S_JAL);
            default: take_exc(op, 2'b01);
        endcase
    endtask

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {7'h00, 7'h23, 7'h2B, 7'h04, 7'h05, 7'h08, 7'h02, 7'h03};
    endfunction

    function automatic vec_t v(input logic [6:0] op, input bit rdy, input bit clr,
                               input int st, input logic [1:0] code);
        vec_t r;
        r.op = op; r.rdy = rdy; r.clr = clr; r.st = st; r.code = code;
        return r;
    endfunction

    initial begin
        vec_t       tbl[$];
        logic [6:0] legal[8];
        logic [6:0] op;
        int         w1, w2;

        tbl.push_back(v(7'h23, 1, 0, S_FETCH, 0));  tbl.push_back(v(7'h23, 0, 0, S_DECODE, 0));
        tbl.push_back(v(7'h23, 0, 0, S_MEMADR, 0)); tbl.push_back(v(7'h23, 1, 0, S_MEMRD, 0));
        tbl.push_back(v(7'h23, 0, 0, S_MEMWB, 0));
        tbl.push_back(v(7'h2B, 1, 0, S_FETCH, 0));  tbl.push_back(v(7'h2B, 0, 0, S_DECODE, 0));
        tbl.push_back(v(7'h2B, 1, 0, S_MEMADR, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(v(7'h2B, 0, 0, S_MEMWR, 0));
        tbl.push_back(v(7'h2B, 1, 0, S_MEMWR, 0));
        tbl.push_back(v(7'h05, 1, 0, S_FETCH, 0));  tbl.push_back(v(7'h05, 0, 0, S_DECODE, 0));
        tbl.push_back(v(7'h05, 0, 0, S_BRANCH, 0));
        tbl.push_back(v(7'h04, 1, 0, S_FETCH, 0));  tbl.push_back(v(7'h04, 0, 0, S_DECODE, 0));
        tbl.push_back(v(7'h04, 0, 0, S_BRANCH, 0));
        tbl.push_back(v(7'h03, 1, 0, S_FETCH, 0));  tbl.push_back(v(7'h03, 0, 0, S_DECODE, 0));
        tbl.push_back(v(7'h03, 0, 0, S_JAL, 0));
        tbl.push_back(v(7'h3F, 1, 0, S_FETCH, 0));  tbl.push_back(v(7'h3F, 0, 0, S_DECODE, 0));
        tbl.push_back(v(7'h3F, 0, 0, S_EXC, 1));    tbl.push_back(v(7'h3F, 1, 0, S_EXC, 1));
        tbl.push_back(v(7'h3F, 0, 1, S_EXC, 1));
        tbl.push_back(v(7'h40, 1, 0, S_FETCH, 0));  tbl.push_back(v(7'h40, 0, 0, S_DECODE, 0));
        tbl.push_back(v(7'h40, 0, 1, S_EXC, 1));
        tbl.push_back(v(7'h00, 0, 0, S_FETCH, 0));  tbl.push_back(v(7'h00, 1, 0, S_FETCH, 0));
        tbl.push_back(v(7'h00, 0, 0, S_DECODE, 0)); tbl.push_back(v(7'h00, 0, 0, S_EXEC, 0));
        tbl.push_back(v(7'h00, 0, 0, S_RTYPE_WB, 0));
        tbl.push_back(v(7'h08, 1, 0, S_FETCH, 0));  tbl.push_back(v(7'h08, 0, 0, S_DECODE, 0));
        tbl.push_back(v(7'h08, 0, 0, S_ADDI_EX, 0)); tbl.push_back(v(7'h08, 0, 0, S_ADDI_WB, 0));
        tbl.push_back(v(7'h02, 1, 0, S_FETCH, 0));  tbl.push_back(v(7'h02, 0, 0, S_DECODE, 0));
        tbl.push_back(v(7'h02, 0, 0, S_JUMP, 0));

        // Reset: everything zero while rst is low, released at the first falling edge.
        mem_ready = 1'b1;
        op_code   = 7'h23;
        #2;
        check("reset state", 32'(state), 32'(S_RST));
        check("reset ctl", 32'(got), 32'h0);
        check("reset ctl dut0", 32'(got0), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post-release state", 32'(state), 32'(S_RST));

        tag = "table";
        foreach (tbl[i]) apply(tbl[i].op, tbl[i].rdy, tbl[i].clr, tbl[i].st, tbl[i].code);

        tag = "fetch timeout";
        run_instr(7'h23, MAXW, 0);
        tag = "fetch ready at limit";
        run_instr(7'h23, MAXW - 1, 0);
        tag = "memrd timeout";
        run_instr(7'h23, 0, MAXW);
        tag = "memwr ready at limit";
        run_instr(7'h2B, 0, MAXW - 1);
        tag = "memwr timeout";
        run_instr(7'h2B, 2, MAXW);

        // Reset in the middle of a store wait: strobes drop at once.
        tag = "mid-memwr reset";
        apply(7'h2B, 1, 0, S_FETCH, 0);
        apply(7'h2B, 0, 0, S_DECODE, 0);
        apply(7'h2B, 0, 0, S_MEMADR, 0);
        apply(7'h2B, 0, 0, S_MEMWR, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("mid-memwr reset state", 32'(state), 32'(S_RST));
        check("mid-memwr reset ctl", 32'(got), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        tag = "random";
        legal = '{7'h00, 7'h23, 7'h2B, 7'h04, 7'h05, 7'h08, 7'h02, 7'h03};
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                8: begin
                    do op = 7'($urandom_range(0, 63)); while (is_legal(op));
                end
                9: op = 7'h40 | 7'($urandom_range(0, 63));
                default: op = legal[$urandom_range(0, 7)];
            endcase
            w1 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(MAXW - 2, MAXW + 1))
                                             : int'($urandom_range(0, 3));
            w2 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(MAXW - 2, MAXW + 1))
                                             : int'($urandom_range(0, 3));
            run_instr(op, w1, w2);
        end

        // Timeout disabled: FETCH waits indefinitely, then an async reset aborts it.
        tag = "no timeout";
        @(negedge clk);
        mem_ready = 1'b0;
        rst0      = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            check("no-timeout state", 32'(d0_state), 32'(S_FETCH));
        end
        check("no-timeout irwrite", 32'(d0_IRwrite), 32'h0);
        @(posedge clk);
        #3;
        rst0 = 1'b0;
        #1;
        check("mid-wait reset state", 32'(d0_state), 32'(S_RST));
        check("mid-wait reset ctl", 32'(got0), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cu_sm_mw.md
Name: cu_sm_mw

Overview:
- Parametrised successor to the multi-cycle MIPS control FSM.
- Adds memory wait-state handshake (mem_ready) with a programmable timeout, bne/addi/jal support, explicit RegWrite and a widened RegDst.
- Adds an illegal-opcode/timeout exception state, a per-instruction completion pulse and a debug state output.
- Drives the existing multi-cycle datapath: PC, IR, MDR, register file, ALU, unified memory.

Parameters:
- OPW, 7, op_code width (≥6); bits above [5:0] must be zero or the opcode is illegal.
- MAX_WAIT, 15, max cycles a memory state waits for mem_ready; 0 disables the timeout.
- SW, 4, state register width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- op_code  in  OPW  IR opcode field, stable from DECODE until the instruction ends
- mem_ready  in  1  memory access complete this cycle
- exc_clear  in  1  leave EXC state
- RegDst  out  2  00 rt, 01 rd, 10 $31
- RegWrite  out  1  register file write
- Memwrite  out  1  memory write
- Memread  out  1  memory read
- Memtoreg  out  2  00 ALUOut, 01 MDR, 10 PC
- ALUop  out  2  00 add, 01 sub, 10 funct
- PCwrite_cond  out  1  conditional PC write
- branch_ne  out  1  invert zero for the condition (bne)
- PCwrite  out  1  unconditional PC write
- PCsrc  out  2  00 ALU, 01 ALUOut, 10 jump target
- ALUsrcA  out  1  0 PC, 1 A
- ALUsrcB  out  2  00 B, 01 const 4, 10 signext, 11 signext<<2
- IRwrite  out  1  load IR
- IorD  out  1  0 PC address, 1 ALUOut address
- instr_done  out  1  1-cycle pulse in the final cycle of each instruction
- exc  out  1  high while in EXC
- exc_code  out  2  01 illegal opcode, 10 memory timeout; holds until exc_clear
- state  out  SW  current state, for debug

Behaviour:
- rst=0 forces state=RST asynchronously.
- In RST every output is 0, including exc_code; the next edge goes to FETCH.
- Outputs are Moore decodes of state, except IRwrite/PCwrite in FETCH and instr_done in MEMWR, which are gated by mem_ready.
- Unlisted outputs are 0 in each state.
- FETCH:
  - Memread=1, IorD=0, ALUsrcA=0, ALUsrcB=01, ALUop=00, PCsrc=00.
  - IRwrite=PCwrite=mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: ALUsrcB=11, ALUop=00. Dispatch on op_code:
  - 0x00 → EXEC
  - 0x23 or 0x2B → MEMADR
  - 0x04 or 0x05 → BRANCH
  - 0x08 → ADDI_EX
  - 0x02 → JUMP
  - 0x03 → JAL
  - anything else (including nonzero upper bits) → EXC with exc_code=01
- MEMADR and ADDI_EX: ALUsrcA=1, ALUsrcB=10, ALUop=00.
  - MEMADR → MEMRD if op is lw, else MEMWR.
  - ADDI_EX → ADDI_WB.
- MEMRD: Memread=1, IorD=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: RegWrite=1, RegDst=00, Memtoreg=01, instr_done=1 → FETCH.
- MEMWR: Memwrite=1, IorD=1, held until mem_ready; then instr_done=1 → FETCH.
- EXEC: ALUsrcA=1, ALUsrcB=00, ALUop=10 → RTYPE_WB.
- RTYPE_WB: RegWrite=1, RegDst=01, Memtoreg=00, instr_done → FETCH.
- ADDI_WB: RegWrite=1, RegDst=00, Memtoreg=00, instr_done → FETCH.
- BRANCH:
  - ALUsrcA=1, ALUsrcB=00, ALUop=01, PCwrite_cond=1, PCsrc=01.
  - branch_ne=(op_code==0x05).
  - instr_done → FETCH.
- JUMP: PCwrite=1, PCsrc=10, instr_done → FETCH.
- JAL: PCwrite=1, PCsrc=10, RegWrite=1, RegDst=10, Memtoreg=10, instr_done → FETCH.
- EXC: exc=1; all control outputs 0; stays until exc_clear=1, then → FETCH and exc_code clears.
- Wait counter:
  - Counts cycles spent in FETCH/MEMRD/MEMWR with mem_ready=0; clears on any state change.
  - If MAX_WAIT≠0 and the counter reaches MAX_WAIT with mem_ready still 0 → EXC with exc_code=10. No write strobe fires on that edge.
  - If mem_ready rises on the same edge as the timeout, mem_ready wins.
- A mid-instruction reset aborts immediately; no partial write strobe is emitted after rst falls.

Decomposition:
- Shared header cu_defs.vh holds:
  - opcode constants (R, LW, SW, BEQ, BNE, ADDI, J, JAL)
  - state encodings (RST=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RTYPE_WB=8, BRANCH=9, JUMP=10, ADDI_EX=11, ADDI_WB=12, JAL=13, EXC=14)
  - ALUop/PCsrc/Memtoreg/RegDst/exc_code encodings
- One sub-module, mem_wait_timer (parameter MAX_WAIT; inputs clk, rst, active, mem_ready; output timeout).

Test Plan:
- Reset low 10 ns then high, mem_ready=1, op=0x23 → state RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB; instr_done on MEMWB; back in FETCH 5 cycles after the first FETCH; all outputs 0 during reset.
- op=0x2B, mem_ready low for 3 cycles in MEMWR → Memwrite=1, IorD=1 for 4 cycles; instr_done only in the 4th; then FETCH.
- op=0x05 → BRANCH with PCwrite_cond=1, branch_ne=1, ALUop=01, PCsrc=01. Repeat with op=0x04 → branch_ne=0.
- op=0x03 → JAL with RegDst=10, Memtoreg=10, RegWrite=1, PCwrite=1, PCsrc=10.
- op=0x3F; then op=0x40 with OPW=7 → EXC with exc_code=01 and all controls 0; exc_clear=1 → FETCH next cycle, exc_code=00.
- MAX_WAIT=15, mem_ready held 0 in FETCH → EXC with exc_code=10 after 15 cycles, IRwrite never asserted. Repeat with MAX_WAIT=0 → waits indefinitely. Assert reset mid-wait → RST immediately.
